// File: rtl/instr_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl_pkg
//  Purpose  : Shared constants, FSM encodings and the fetch queue entry type
//             used by the instruction fetch sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package instr_fetch_ctrl_pkg;

    // Instruction words the fetch unit needs to recognise or reset to
    localparam logic [31:0] c_instr_ebreak = 32'h0010_0073;
    localparam logic [31:0] c_instr_nop    = 32'h0000_0013;

    // Fetch FSM encodings
    localparam logic [1:0] c_fetch_run          = 2'd0;
    localparam logic [1:0] c_fetch_halt_ebreak  = 2'd1;
    localparam logic [1:0] c_fetch_halt_misalign = 2'd2;

    // One queued fetch: the byte address and the word read from it
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses must be word aligned
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ctrl_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl_fetch_queue
//  Purpose  : Small synchronous FIFO of {pc, instr} entries between fetch and
//             decode. Flush empties it in one cycle; simultaneous push and
//             pop are accepted when full.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_ctrl_fetch_queue
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full,
    output logic         empty
);

    localparam int            c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    fetch_entry_t    r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees the slot being written, so push is legal when full if popping
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer and occupancy bookkeeping; flush returns everything to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; slots are only read while occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{pc: 32'h0, instr: c_instr_nop};
            end
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl
//  Purpose  : Fetch sequencer in front of the instruction memory. Owns the PC,
//             queues fetched {pc, instr} pairs for decode, applies redirects
//             from execute and halts on EBREAK or a misaligned target.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        misaligned_err
);

    logic [31:0]  r_pc;
    logic [1:0]   r_state;
    logic         r_misaligned;
    fetch_entry_t r_last;

    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_head;
    fetch_entry_t w_fetch;

    assign imem_addr = r_pc;
    assign w_fetch   = '{pc: r_pc, instr: imem_rdata};

    // Redirect suppresses both queue operations for the cycle
    assign w_pop  = !w_empty && out_ready && !redirect_valid;
    assign w_push = (r_state == c_fetch_run) && !redirect_valid && (!w_full || w_pop);

    instr_fetch_ctrl_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .din   (w_fetch),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Program counter: redirect target wins, otherwise advance on each fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Fetch FSM: halt states are only left through a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_fetch_run;
        end else if (redirect_valid) begin
            r_state <= is_aligned(redirect_pc) ? c_fetch_run : c_fetch_halt_misalign;
        end else if (w_push && (imem_rdata == c_instr_ebreak)) begin
            r_state <= c_fetch_halt_ebreak;
        end
    end

    // Sticky flag describing the most recent redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (redirect_valid) begin
            r_misaligned <= !is_aligned(redirect_pc);
        end
    end

    // Remember the head last shown so out_pc/out_instr hold once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
        end else if (!w_empty) begin
            r_last <= w_head;
        end
    end

    assign out_valid      = !w_empty;
    assign out_pc         = w_empty ? r_last.pc    : w_head.pc;
    assign out_instr      = w_empty ? r_last.instr : w_head.instr;
    assign halted         = (r_state != c_fetch_run);
    assign misaligned_err = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_ctrl
//  Purpose  : Self-checking bench for instr_fetch_ctrl: directed vector table,
//             randomized run against a queue-based reference model, PC wrap
//             and asynchronous reset corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam logic [31:0] c_ebreak = 32'h0010_0073;
    localparam logic [31:0] c_nop    = 32'h0000_0013;
    localparam logic [31:0] c_addi0  = 32'h0010_0093;
    localparam logic [31:0] c_addi1  = 32'h0020_0113;
    localparam logic [31:0] c_addi2  = 32'h0030_0193;
    localparam int          c_depth  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_halt;
        bit          e_merr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n2;
    logic [31:0] imem_addr, imem_rdata, imem_addr2, imem_rdata2;
    logic        out_valid, out_valid2, out_ready, out_ready2;
    logic [31:0] out_pc, out_instr, out_pc2, out_instr2;
    logic        redirect_valid, redirect_valid2;
    logic [31:0] redirect_pc, redirect_pc2;
    logic        halted, halted2, misaligned_err, misaligned_err2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_show_pc;
    logic [31:0] m_show_instr;
    bit          m_halted;
    bit          m_merr;

    vec_t vecs[22];

    always #5 clk = ~clk;

    // Program image: addi at 0x0/0x4/0x8, EBREAK at 0x10, NOP elsewhere
    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h0:   return c_addi0;
            32'h4:   return c_addi1;
            32'h8:   return c_addi2;
            32'h10:  return c_ebreak;
            default: return c_nop;
        endcase
    endfunction

    assign imem_rdata  = img(imem_addr);
    assign imem_rdata2 = img(imem_addr2);

    instr_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (c_depth)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misaligned_err (misaligned_err)
    );

    instr_fetch_ctrl #(
        .RESET_PC    (32'hFFFF_FFFC),
        .QUEUE_DEPTH (c_depth)
    ) u_dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n2),
        .imem_addr      (imem_addr2),
        .imem_rdata     (imem_rdata2),
        .out_valid      (out_valid2),
        .out_ready      (out_ready2),
        .out_pc         (out_pc2),
        .out_instr      (out_instr2),
        .redirect_valid (redirect_valid2),
        .redirect_pc    (redirect_pc2),
        .halted         (halted2),
        .misaligned_err (misaligned_err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset(input logic [31:0] pc0);
        mq.delete();
        m_pc         = pc0;
        m_show_pc    = 32'h0;
        m_show_instr = 32'h0;
        m_halted     = 1'b0;
        m_merr       = 1'b0;
    endtask

    // One clock of the fetch rules, written over a plain queue
    task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rpc);
        ent_t e;
        if (rv) begin
            mq.delete();
            m_pc     = rpc;
            m_merr   = (rpc[1:0] != 2'b00);
            m_halted = m_merr;
        end else begin
            if (mq.size() > 0 && rdy) begin
                void'(mq.pop_front());
            end
            if (!m_halted && mq.size() < c_depth) begin
                e.pc    = m_pc;
                e.instr = img(m_pc);
                mq.push_back(e);
                if (e.instr == c_ebreak) m_halted = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        if (mq.size() > 0) begin
            m_show_pc    = mq[0].pc;
            m_show_instr = mq[0].instr;
        end
    endtask

    task automatic model_compare();
        check("rand_addr",   imem_addr,              m_pc);
        check("rand_valid",  32'(out_valid),         32'(mq.size() > 0));
        check("rand_pc",     out_pc,                 m_show_pc);
        check("rand_instr",  out_instr,              m_show_instr);
        check("rand_halted", 32'(halted),            32'(m_halted));
        check("rand_merr",   32'(misaligned_err),    32'(m_merr));
    endtask

    task automatic set_vec(input int i, input bit rdy, input bit rv, input logic [31:0] rpc,
                           input logic [31:0] ea, input bit ev, input logic [31:0] ep,
                           input bit eh, input bit em);
        vecs[i] = '{rdy, rv, rpc, ea, ev, ep, eh, em};
    endtask

    initial begin
        bit          r_rdy, r_rv;
        logic [31:0] r_rpc;

        // Directed vectors: inputs for the cycle, outputs seen before its edge
        set_vec( 0, 1, 0, 32'h0,  32'h0,  0, 32'h0,  0, 0);
        set_vec( 1, 1, 0, 32'h0,  32'h4,  1, 32'h0,  0, 0);
        set_vec( 2, 1, 0, 32'h0,  32'h8,  1, 32'h4,  0, 0);
        set_vec( 3, 1, 0, 32'h0,  32'hC,  1, 32'h8,  0, 0);
        set_vec( 4, 1, 0, 32'h0,  32'h10, 1, 32'hC,  0, 0);
        set_vec( 5, 1, 0, 32'h0,  32'h14, 1, 32'h10, 1, 0);
        set_vec( 6, 1, 1, 32'h0,  32'h14, 0, 32'h10, 1, 0);
        set_vec( 7, 1, 0, 32'h0,  32'h0,  0, 32'h10, 0, 0);
        set_vec( 8, 0, 0, 32'h0,  32'h4,  1, 32'h0,  0, 0);
        set_vec( 9, 0, 0, 32'h0,  32'h8,  1, 32'h0,  0, 0);
        set_vec(10, 1, 0, 32'h0,  32'h8,  1, 32'h0,  0, 0);
        set_vec(11, 0, 0, 32'h0,  32'hC,  1, 32'h4,  0, 0);
        set_vec(12, 1, 1, 32'h8,  32'hC,  1, 32'h4,  0, 0);
        set_vec(13, 1, 0, 32'h0,  32'h8,  0, 32'h4,  0, 0);
        set_vec(14, 1, 1, 32'h6,  32'hC,  1, 32'h8,  0, 0);
        set_vec(15, 1, 0, 32'h0,  32'h6,  0, 32'h8,  1, 1);
        set_vec(16, 1, 1, 32'h4,  32'h6,  0, 32'h8,  1, 1);
        set_vec(17, 1, 0, 32'h0,  32'h4,  0, 32'h8,  0, 0);
        set_vec(18, 1, 1, 32'h10, 32'h8,  1, 32'h4,  0, 0);
        set_vec(19, 1, 1, 32'h0,  32'h10, 0, 32'h4,  0, 0);
        set_vec(20, 1, 0, 32'h0,  32'h0,  0, 32'h4,  0, 0);
        set_vec(21, 1, 0, 32'h0,  32'h4,  1, 32'h0,  0, 0);

        rst_n           = 1'b0;
        rst_n2          = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        out_ready2      = 1'b1;
        redirect_valid2 = 1'b0;
        redirect_pc2    = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_addr",   imem_addr,            32'h0);
        check("reset_valid",  32'(out_valid),       32'h0);
        check("reset_pc",     out_pc,               32'h0);
        check("reset_instr",  out_instr,            32'h0);
        check("reset_halted", 32'(halted),          32'h0);
        check("reset_merr",   32'(misaligned_err),  32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            check($sformatf("vec%0d_addr", i),   imem_addr,           vecs[i].e_addr);
            check($sformatf("vec%0d_valid", i),  32'(out_valid),      32'(vecs[i].e_valid));
            check($sformatf("vec%0d_pc", i),     out_pc,              vecs[i].e_pc);
            check($sformatf("vec%0d_halted", i), 32'(halted),         32'(vecs[i].e_halt));
            check($sformatf("vec%0d_merr", i),   32'(misaligned_err), 32'(vecs[i].e_merr));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_instr", i), out_instr, img(vecs[i].e_pc));
            end
            @(posedge clk);
            #1;
        end

        // Randomized run against the reference model
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(32'h0);
        for (int n = 0; n < 1500; n++) begin
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
            r_rpc = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) r_rpc = r_rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) r_rpc = 32'hFFFF_FFF8;
            out_ready      = r_rdy;
            redirect_valid = r_rv;
            redirect_pc    = r_rpc;
            model_compare();
            model_step(r_rdy, r_rv, r_rpc);
            @(posedge clk);
            #1;
        end
        model_compare();

        // Reset asserted between edges must clear the outputs immediately
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",  32'(out_valid), 32'h0);
        check("async_rst_pc",     out_pc,         32'h0);
        check("async_rst_halted", 32'(halted),    32'h0);
        check("async_rst_addr",   imem_addr,      32'h0);

        // PC wrap from the top of the address space
        @(posedge clk);
        #1;
        rst_n2 = 1'b1;
        check("wrap_addr0",  imem_addr2,           32'hFFFF_FFFC);
        check("wrap_valid0", 32'(out_valid2),      32'h0);
        @(posedge clk);
        #1;
        check("wrap_addr1",  imem_addr2,           32'h0);
        check("wrap_valid1", 32'(out_valid2),      32'h1);
        check("wrap_pc1",    out_pc2,              32'hFFFF_FFFC);
        check("wrap_instr1", out_instr2,           c_nop);
        @(posedge clk);
        #1;
        check("wrap_addr2",  imem_addr2,           32'h4);
        check("wrap_pc2",    out_pc2,              32'h0);
        check("wrap_halted", 32'(halted2),         32'h0);
        check("wrap_merr",   32'(misaligned_err2), 32'h0);
        #2;
        rst_n2 = 1'b0;
        #1;
        check("wrap_rst_valid", 32'(out_valid2), 32'h0);
        check("wrap_rst_addr",  imem_addr2,      32'hFFFF_FFFC);
        check("wrap_rst_pc",    out_pc2,         32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
